// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, opcode encoding and helpers.
package instr_fetch_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned QDEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } fetch_state_t;

    typedef enum logic [INSTR_W-1:0] {
        HALT = 8'b0111_1000
    } op_code_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] op);
        return op == HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry instruction/PC FIFO with a registered head; flush beats push.
module instr_fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned PC_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [PC_W-1:0]    push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [INSTR_W-1:0] head_instr,
    output logic [PC_W-1:0]    head_pc
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } q_entry_t;

    q_entry_t head_q;
    q_entry_t tail_q;
    q_entry_t din;
    logic     pop_ok;

    assign din        = '{instr: push_instr, pc: push_pc};
    assign pop_ok     = pop && (count != 2'd0);
    assign head_instr = head_q.instr;
    assign head_pc    = head_q.pc;

    // Entry 0 is always the head, so the outputs come straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= din;
                        count  <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail_q <= din;
                        count  <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the instruction ROM under a two-credit window and
// presents bytes to decode; handles branch redirects and stops on HALT.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               busy,
    output logic               halted
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [1:0]      q_count;
    logic [1:0]      occupancy;
    logic            in_fetch;
    logic            pop;
    logic            redirect;
    logic            halt_pop;
    logic            kill;
    logic            issue;
    logic            push;

    assign in_fetch    = (state == FETCH);
    assign instr_valid = (q_count != 2'd0);
    assign pop         = in_fetch && instr_valid && instr_ready;
    assign redirect    = in_fetch && br_taken;
    assign halt_pop    = pop && is_halt(instr) && !br_taken;
    assign kill        = redirect || halt_pop;

    // Credits cover both buffered bytes and the read whose data lands this cycle.
    assign occupancy = q_count + {1'b0, inflight};
    assign issue     = in_fetch && !kill &&
                       ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
    assign push      = inflight && !kill;

    assign imem_rd   = issue;
    assign imem_addr = pc;
    assign busy      = in_fetch;
    assign halted    = (state == HALTED);

    instr_fetch_queue #(
        .PC_W(PC_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem_data),
        .push_pc    (inflight_pc),
        .pop        (pop),
        .flush      (kill),
        .count      (q_count),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            unique case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= START_PC;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        pc <= br_target;
                    end else if (halt_pop) begin
                        state <= HALTED;
                    end else if (issue) begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {instr, pc} pairs are queued as stimulus
// is driven and compared whenever decode accepts a byte.
module tb_instr_fetch;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned DEPTH = 1 << PC_W;

    typedef struct packed {
        logic [7:0]      instr;
        logic [PC_W-1:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            imem_rd;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic [7:0]      instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            busy;
    logic            halted;

    logic [7:0] rom [0:DEPTH-1];
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;

    instr_fetch #(
        .PC_W       (PC_W),
        .START_ADDR (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM; garbage when not read so stray captures show up.
    always @(posedge clk) imem_data <= imem_rd ? rom[imem_addr] : 8'hEE;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned a);
        exp_t e;
        e.instr = rom[a];
        e.pc    = PC_W'(a);
        sb.push_back(e);
    endtask

    task automatic expect_prog();
        for (int a = 0; a < 4; a++) expect_at(a);
    endtask

    task automatic wait_halted(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rd_off"}, 32'(imem_rd), 32'd0);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard consumer: every accepted byte must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pc", 32'(instr_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr", 32'(instr), 32'(e.instr));
                check("sb_pc", 32'(instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        int bad;

        for (int i = 0; i < DEPTH; i++) rom[i] = 8'((i * 7) % 100);
        rom[0] = 8'h01;
        rom[1] = 8'h42;
        rom[2] = 8'h81;
        rom[3] = 8'h78;

        rst_n       = 1'b0;
        start       = 1'b0;
        instr_ready = 1'b1;
        br_taken    = 1'b0;
        br_target   = '0;

        // Reset values
        @(negedge clk);
        check("rst_imem_rd", 32'(imem_rd), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Straight-line program with ready held high, ending on HALT
        expect_prog();
        start = 1'b1;
        @(negedge clk);
        check("t0_idle_no_rd", 32'(imem_rd), 32'd0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t1_rd", 32'(imem_rd), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("t2_valid_low", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t3_valid_high", 32'(instr_valid), 32'd1);
        wait_halted("prog", 20);

        // Decode stalled: two credits only, then back-to-back drain
        instr_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start  = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_rd) rd_cnt++;
            tick();
        end
        @(negedge clk);
        check("stall_rd_pulses", 32'(rd_cnt), 32'd2);
        check("stall_rd_now", 32'(imem_rd), 32'd0);
        check("stall_head_instr", 32'(instr), 32'h01);
        check("stall_head_pc", 32'(instr_pc), 32'd0);
        expect_prog();
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_no_gap", 32'(instr_valid), 32'd1);
            tick();
        end
        wait_halted("stall", 10);

        // Redirect with a read in flight; stream wraps through 0x3FF into the program
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        br_taken  = 1'b1;
        br_target = 10'h3F0;
        for (int a = 10'h3F0; a < DEPTH; a++) expect_at(a);
        expect_prog();
        tick();
        br_taken = 1'b0;
        @(negedge clk);
        check("br_rd", 32'(imem_rd), 32'd1);
        check("br_addr", 32'(imem_addr), 32'h3F0);
        check("br_valid_t1", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("br_valid_t2", 32'(instr_valid), 32'd0);
        wait_halted("wrap", 40);

        // HALT accepted in the same cycle as a branch: the branch wins
        expect_prog();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            bool_wait : for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (instr_valid && instr_pc == PC_W'(2)) break;
            end
        end
        check("pre_halt_pc", 32'(instr_pc), 32'd2);
        tick();
        br_taken  = 1'b1;
        br_target = 10'h010;
        tick();
        br_taken    = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        check("hb_not_halted", 32'(halted), 32'd0);
        check("hb_busy", 32'(busy), 32'd1);
        check("hb_rd", 32'(imem_rd), 32'd1);
        check("hb_addr", 32'(imem_addr), 32'h010);
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("hb_valid", 32'(instr_valid), 32'd1);
        check("hb_instr", 32'(instr), 32'(rom[10'h010]));
        check("hb_pc", 32'(instr_pc), 32'h010);
        tick();
        br_taken  = 1'b1;
        br_target = 10'h000;
        expect_prog();
        tick();
        br_taken    = 1'b0;
        instr_ready = 1'b1;
        wait_halted("hb", 20);

        // Restart from HALTED goes back to the start address
        expect_prog();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("restart_rd", 32'(imem_rd), 32'd1);
        check("restart_addr", 32'(imem_addr), 32'd0);
        wait_halted("restart", 20);

        // Asynchronous reset with a read in flight
        instr_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_rd", 32'(imem_rd), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_instr", 32'(instr), 32'd0);
        check("arst_instr_pc", 32'(instr_pc), 32'd0);
        #1;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid || imem_rd || busy || halted) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        check("post_rst_sb", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit accumulator-style CPU. It owns the program counter, reads one-byte instructions from a synchronous instruction ROM and hands them to the decode stage through a valid/ready handshake. It buffers fetched bytes in a two-entry queue so that fetch continues while decode is stalled. It accepts taken-branch redirects (BLT/BNE resolved downstream) and stops fetching when the HALT opcode is consumed.

## Interface
- PC_W, 10, program-counter / instruction-ROM address width (ROM depth 2^PC_W bytes)
- START_ADDR, 0, PC value loaded on reset and on every start
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins fetching at START_ADDR (honoured in IDLE and HALTED only)
- imem_rd  out  1  ROM read strobe
- imem_addr  out  PC_W  ROM read address; meaningful when imem_rd=1
- imem_data  in  8  ROM data; valid exactly one cycle after the imem_rd cycle
- instr  out  8  head-of-queue instruction byte (op_code encoding)
- instr_pc  out  PC_W  address of instr
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode accepts instr; pop = instr_valid & instr_ready
- br_taken  in  1  redirect request from execute
- br_target  in  PC_W  redirect address, sampled when br_taken=1
- busy  out  1  state == FETCH
- halted  out  1  state == HALTED

## Operation
- States: IDLE, FETCH, HALTED. Reset → IDLE.
- IDLE: no reads. start → FETCH, PC ← START_ADDR.
- FETCH: issue a read (imem_rd=1, imem_addr=PC, PC ← PC+1) whenever a credit is free: count + inflight < 2, or count + inflight == 2 with a pop in the same cycle. count = queue occupancy (0..2); inflight = read issued last cycle and not killed.
- Response: the cycle after a non-killed read, {imem_data, issuing PC} is pushed to the queue tail. Push and pop may occur in the same cycle.
- PC arithmetic: unsigned modulo 2^PC_W; 2^PC_W−1 wraps to 0 with no flag.
- Redirect: br_taken=1 in FETCH flushes the queue (count ← 0), kills the in-flight read (its data arriving next cycle is dropped), and sets PC ← br_target. A pop in the same cycle is ignored. br_taken in IDLE or HALTED is ignored.
- Halt: a pop of instr == 8'b01111000 (HALT) moves the block to HALTED next cycle. The queue is flushed and the in-flight read is killed. If br_taken is asserted in the same cycle, the branch wins and there is no halt.
- HALTED: no reads; instr_valid=0. start → FETCH at START_ADDR. start in FETCH is ignored.
- The block decodes no opcode other than HALT; IMME/ALW/ASW etc. pass through unmodified.

## Timing
- Reset values: imem_rd=0, imem_addr=START_ADDR, instr=0, instr_pc=0, instr_valid=0, busy=0, halted=0; PC=START_ADDR, count=0, inflight=0.
- start at cycle t: first imem_rd at t+1, first instr_valid at t+3 (read t+1, data t+2, registered into queue).
- Steady state with instr_ready held 1: one instruction per cycle, consecutive PCs.
- instr_ready=0: at most 2 reads outstanding-or-buffered; imem_rd drops once count+inflight=2. The next read is issued in the same cycle as the releasing pop.
- br_taken at t: imem_rd with imem_addr=br_target at t+1; instr_valid at t+3; instr_valid=0 during t+1..t+2.
- HALT pop at t: halted=1 and busy=0 from t+1; imem_rd=0 from t+1.
- Asynchronous reset mid-operation: immediate return to reset values. ROM data returning after reset release is ignored (inflight cleared).
- Outputs instr, instr_pc and instr_valid are registered (no combinational path from instr_ready or br_taken).

## Structure
- Shared package definitions gains: typedef enum fetch_state_t {IDLE, FETCH, HALTED}. HALT is compared through the existing op_code encoding, not a local literal.
- Sub-module fetch_queue: 2-entry FIFO of {8-bit instr, PC_W-bit pc}, with push, pop, flush, count and head outputs. Registered head; simultaneous push+pop allowed at count 1 and 2; flush has priority over push.

## Test plan
- Reset, start pulse, ROM[0..3]=0x01,0x42,0x81,0x78, instr_ready=1 → instr 0x01@pc0 at t+3, then one per cycle. After the pop of 0x78, halted=1 and imem_rd=0.
- instr_ready=0 for 5 cycles after start → exactly 2 imem_rd pulses, count=2, instr stays 0x01. Releasing ready delivers 0x01, 0x42, 0x81 back-to-back with no gaps or duplicates.
- br_taken with br_target=0x3F0 while a read is in flight → the in-flight byte is never presented. The next imem_addr is 0x3F0, and instr_pc=0x3F0 at t+3.
- PC_W=10, br_target=0x3FF, sequential fetch → instr_pc sequence 0x3FF, 0x000, 0x001.
- HALT popped in the same cycle as br_taken to 0x010 → halted stays 0 and fetch resumes at 0x010. A later start while HALTED restarts at START_ADDR.
- rst_n asserted low mid-fetch with inflight=1 → all outputs at reset values immediately. After release with no start, no instr_valid ever rises.
